instruction_prefetch_unit: RTL and testbench
============================================

# instruction_prefetch_unit

Parametrised fetch stage with a decoupled instruction memory interface and a prefetch queue. Keeps its own fetch PC, issues sequential requests to a variable-latency instruction memory, and buffers returned instructions with their PC and link value (PC+4) for the decode stage. Redirects from the execute stage (conditional/unconditional PC-relative branch, or register branch) flush the queue and discard any stale in-flight response. Replaces the single-cycle fetch path.

## Interface
- ADDR_W, 64, PC/address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch queue entries (power of two, >=2)
- RESET_PC, 0, fetch address after reset
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- redirect_br  in  1  PC-relative branch taken (the or of conditional and unconditional branch)
- br_target  in  ADDR_W  PC-relative target
- redirect_reg  in  1  register branch (BR/BLR/RET)
- reg_target  in  ADDR_W  register value (read data 1)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  request address
- imem_rsp_valid  in  1  response valid (one pulse per accepted request, in order)
- imem_rsp_data  in  INSTR_W  instruction word
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head (deasserted = hazard stall)
- if_instr  out  INSTR_W  head instruction
- if_pc  out  ADDR_W  head PC
- if_pc_link  out  ADDR_W  head PC+4 (link value)

## Operation
- Reset: fetch_pc=RESET_PC, queue empty, state RUN, imem_req_valid=0, if_valid=0, outputs 0.
- Redirect: redirect_reg has priority over redirect_br. On either: fetch_pc<=selected target, queue cleared (count=0), any unaccepted request withdrawn.
- FSM states:
  - RUN: no request outstanding. imem_req_valid=1 iff count<DEPTH and no redirect this cycle. Handshake (valid&ready) -> WAIT, fetch_pc+=4, captured req_pc=old fetch_pc.
  - WAIT: one request outstanding; imem_req_valid=0. rsp_valid -> push {rsp_data, req_pc, req_pc+4}, go RUN. Redirect -> DRAIN (or RUN if rsp_valid same cycle; response dropped).
  - DRAIN: stale request outstanding; rsp_valid -> discard, go RUN. Further redirects only update fetch_pc.
- Issue gating counts the outstanding request: issue only if count+outstanding<DEPTH, so a push never meets a full queue.
- Pop on if_valid&if_ready. Simultaneous push and pop: count unchanged, both take effect. Redirect in a pop cycle: pop is a legal handshake (decode squashes it); queue still ends empty.
- Arithmetic: PC+4 modulo 2^ADDR_W, wrap-around silent. Low two address bits carried unchanged.
- Reset mid-operation: returns to reset state; a response arriving in the cycle after reset is ignored (state RUN, nothing outstanding is treated as stale).

## Timing
- Outputs registered from queue state; no combinational path from imem_rsp_* or if_ready to if_* outputs.
- imem_req_valid depends on state, count and redirect inputs only (not on imem_req_ready).
- Sequential throughput: one instruction per 1+L cycles for memory latency L>=1 (single outstanding request).
- Redirect in cycle t: first request to target at t+1 (t+1+ stale latency if DRAIN); response at t+1+L; if_valid with target at t+2+L.
- Empty queue, response at t: if_valid at t+1 (no bypass).

## Structure
- Package fetch_pkg: ADDR_W/INSTR_W defaults, INSN_BYTES=4, fetch entry struct {instr, pc, pc_link}, FSM state enum {RUN, WAIT, DRAIN}.
- Sub-module fetch_queue: synchronous FIFO of fetch entries, parameter DEPTH, push/pop/flush, count out, circular pointers with wrap. Top holds PC, FSM, redirect mux, memory handshake.

## Test plan
- Reset then imem_req_ready=1, L=1, if_ready=1 -> requests 0,4,8,...; if_pc 0,4,8 with if_pc_link 4,8,12, if_instr matching memory.
- if_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; if_ready=1 resumes issue next cycle, no entry lost or duplicated.
- redirect_br with br_target=0x100 while WAIT, L=3 -> stale response discarded, next request addr 0x100, first if_pc=0x100.
- redirect_br and redirect_reg together, reg_target=0x2000, br_target=0x100 -> fetch from 0x2000.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC -> following request addr 0, if_pc_link of that entry 0.
- reset asserted in WAIT with response arriving next cycle -> queue empty, if_valid=0, first request addr RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, fetch entry layout and FSM states for the prefetch unit
package fetch_pkg;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_INSTR_W = 32;
    localparam int INSN_BYTES  = 4;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_ADDR_W-1:0]  pc_link;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous circular FIFO of packed fetch entries with flush
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 160
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign do_push    = push && ((count != FULL) || do_pop);

    // Head is masked so an empty queue presents all-zero fields to decode.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// rtl/instruction_prefetch_unit.sv - fetch PC, single-outstanding imem handshake, redirect handling
module instruction_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect_br,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               redirect_reg,
    input  logic [ADDR_W-1:0]  reg_target,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_link
);

    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam int                ENTRY_W  = INSTR_W + 2 * ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSN_BYTES);

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   fetch_pc_nxt;
    logic [ADDR_W-1:0]   req_pc;
    logic [ADDR_W-1:0]   req_pc_nxt;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  push_data;
    logic [ENTRY_W-1:0]  head_data;

    assign redirect      = redirect_br | redirect_reg;
    assign redirect_pc   = redirect_reg ? reg_target : br_target;
    assign imem_req_addr = fetch_pc;
    assign pop           = if_valid && if_ready;
    assign push_data     = {imem_rsp_data, req_pc, req_pc + STEP};

    // Only RUN can issue, and RUN has nothing outstanding, so room in the
    // queue alone guarantees the eventual push never meets a full queue.
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        req_pc_nxt     = req_pc;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        if (redirect) begin
            fetch_pc_nxt = redirect_pc;
        end
        case (state)
            RUN: begin
                imem_req_valid = !reset && !redirect && (count < CNT_FULL);
                if (imem_req_valid && imem_req_ready) begin
                    state_nxt    = WAIT;
                    fetch_pc_nxt = fetch_pc + STEP;
                    req_pc_nxt   = fetch_pc;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = RUN;
                    push      = !redirect;
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (redirect),
        .head_valid (if_valid),
        .head_data  (head_data),
        .count      (count)
    );

    assign if_instr   = head_data[ENTRY_W-1 -: INSTR_W];
    assign if_pc      = head_data[2*ADDR_W-1 -: ADDR_W];
    assign if_pc_link = head_data[ADDR_W-1:0];

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// tb/tb_instruction_prefetch_unit.sv - scoreboard bench with a variable-latency imem model
module tb_instruction_prefetch_unit;
    import fetch_pkg::*;

    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               redirect_br = 1'b0;
    logic [ADDR_W-1:0]  br_target = '0;
    logic               redirect_reg = 1'b0;
    logic [ADDR_W-1:0]  reg_target = '0;
    logic               imem_req_valid;
    logic               imem_req_ready = 1'b1;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rsp_data = '0;
    logic               if_valid;
    logic               if_ready = 1'b1;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc_link;

    instruction_prefetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_br    (redirect_br),
        .br_target      (br_target),
        .redirect_reg   (redirect_reg),
        .reg_target     (reg_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_link     (if_pc_link)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_rsp_t;

    mem_rsp_t     mem_q[$];
    fetch_entry_t exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           n_hs = 0;
    int           n_pop = 0;
    int           lat = 1;
    int           rsp_lat;
    logic [63:0]  exp_addr = RESET_PC;
    fetch_entry_t exp_e;
    fetch_entry_t got_e;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'hC3A5_0F1E;
    endfunction

    // Memory model plus scoreboard; runs 1 time unit after each falling edge.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            cyc++;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_q[0].data;
                void'(mem_q.pop_front());
            end
            if (reset) begin
                exp_q.delete();
                exp_addr = RESET_PC;
            end else begin
                if (if_valid && if_ready) begin
                    n_pop++;
                    n_checks++;
                    got_e = {if_instr, if_pc, if_pc_link};
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL pop_unexpected got pc=%h link=%h instr=%h required no entry", if_pc, if_pc_link, if_instr);
                    end else begin
                        exp_e = exp_q.pop_front();
                        if (got_e !== exp_e) begin
                            n_errors++;
                            $display("FAIL pop_entry got pc=%h link=%h instr=%h required pc=%h link=%h instr=%h",
                                     if_pc, if_pc_link, if_instr, exp_e.pc, exp_e.pc_link, exp_e.instr);
                        end
                    end
                end
                if (redirect_br || redirect_reg) begin
                    n_checks++;
                    if (imem_req_valid !== 1'b0) begin
                        n_errors++;
                        $display("FAIL req_in_redirect got valid=%b required 0", imem_req_valid);
                    end
                    exp_q.delete();
                    exp_addr = redirect_reg ? reg_target : br_target;
                end else if (imem_req_valid && imem_req_ready) begin
                    n_hs++;
                    n_checks++;
                    if (imem_req_addr !== exp_addr) begin
                        n_errors++;
                        $display("FAIL req_addr got %h required %h", imem_req_addr, exp_addr);
                    end
                    exp_q.push_back({mem_word(exp_addr), exp_addr, exp_addr + 64'd4});
                    rsp_lat = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
                    mem_q.push_back('{due: cyc + rsp_lat, data: mem_word(imem_req_addr)});
                    exp_addr = exp_addr + 64'd4;
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset        = 1'b1;
        redirect_br  = 1'b0;
        redirect_reg = 1'b0;
        mem_q.delete();
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        mem_q.delete();
        @(negedge clock);
        #2;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid got %b required 0", imem_req_valid); end
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_if_valid got %b required 0", if_valid); end
        n_checks++; if (if_instr !== '0) begin n_errors++; $display("FAIL reset_if_instr got %h required 0", if_instr); end
        n_checks++; if (if_pc !== '0) begin n_errors++; $display("FAIL reset_if_pc got %h required 0", if_pc); end
        n_checks++; if (if_pc_link !== '0) begin n_errors++; $display("FAIL reset_if_pc_link got %h required 0", if_pc_link); end
        n_checks++; if (imem_req_addr !== RESET_PC) begin n_errors++; $display("FAIL reset_req_addr got %h required %h", imem_req_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        int first;
        int h0;
        lat = 1;
        do_reset(2);
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            #2;
            if (if_valid) begin
                first = k;
                break;
            end
        end
        n_checks++; if (first != 2) begin n_errors++; $display("FAIL first_valid_latency got %0d required 2", first); end
        n_checks++; if (if_pc !== RESET_PC) begin n_errors++; $display("FAIL first_pc got %h required %h", if_pc, RESET_PC); end
        n_checks++; if (if_pc_link !== RESET_PC + 64'd4) begin n_errors++; $display("FAIL first_link got %h required %h", if_pc_link, RESET_PC + 64'd4); end
        n_checks++; if (if_instr !== mem_word(RESET_PC)) begin n_errors++; $display("FAIL first_instr got %h required %h", if_instr, mem_word(RESET_PC)); end
        repeat (4) @(negedge clock);
        h0 = n_hs;
        repeat (20) @(negedge clock);
        n_checks++; if (n_hs - h0 != 10) begin n_errors++; $display("FAIL throughput_l1 got %0d required 10", n_hs - h0); end
        lat = 3;
        repeat (8) @(negedge clock);
        h0 = n_hs;
        repeat (20) @(negedge clock);
        n_checks++; if (n_hs - h0 != 5) begin n_errors++; $display("FAIL throughput_l3 got %0d required 5", n_hs - h0); end
    endtask

    task automatic test_backpressure();
        int h0;
        int p0;
        lat = 2;
        imem_req_ready = 1'b1;
        if_ready = 1'b0;
        do_reset(2);
        h0 = n_hs;
        p0 = n_pop;
        repeat (30) @(negedge clock);
        #2;
        n_checks++; if (n_hs - h0 != DEPTH) begin n_errors++; $display("FAIL stall_requests got %0d required %0d", n_hs - h0, DEPTH); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL stall_req_valid got %b required 0", imem_req_valid); end
        n_checks++; if (if_valid !== 1'b1) begin n_errors++; $display("FAIL stall_if_valid got %b required 1", if_valid); end
        @(negedge clock);
        if_ready = 1'b1;
        @(negedge clock);
        #2;
        n_checks++; if (imem_req_valid !== 1'b1) begin n_errors++; $display("FAIL resume_req_valid got %b required 1", imem_req_valid); end
        repeat (30) @(negedge clock);
        imem_req_ready = 1'b0;
        repeat (15) @(negedge clock);
        #2;
        n_checks++; if (n_pop - p0 != n_hs - h0) begin n_errors++; $display("FAIL drain_balance got pops=%0d required %0d", n_pop - p0, n_hs - h0); end
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty got %b required 0", if_valid); end
        imem_req_ready = 1'b1;
    endtask

    task automatic test_redirect_wait();
        int hs_k;
        int v_k;
        lat = 3;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        do_reset(2);
        @(negedge clock);
        redirect_br = 1'b1;
        br_target = 64'h100;
        @(negedge clock);
        redirect_br = 1'b0;
        hs_k = -1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (imem_req_valid && imem_req_ready) begin
                hs_k = i;
                break;
            end
            @(negedge clock);
        end
        n_checks++; if (hs_k != 2) begin n_errors++; $display("FAIL drain_issue_delay got %0d required 2", hs_k); end
        n_checks++; if (imem_req_addr !== 64'h100) begin n_errors++; $display("FAIL redirect_addr got %h required %h", imem_req_addr, 64'h100); end
        v_k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            #2;
            if (if_valid) begin
                v_k = i;
                break;
            end
        end
        n_checks++; if (v_k != 4) begin n_errors++; $display("FAIL redirect_valid_delay got %0d required 4", v_k); end
        n_checks++; if (if_pc !== 64'h100) begin n_errors++; $display("FAIL redirect_pc got %h required %h", if_pc, 64'h100); end
        n_checks++; if (if_pc_link !== 64'h104) begin n_errors++; $display("FAIL redirect_link got %h required %h", if_pc_link, 64'h104); end
    endtask

    task automatic test_redirect_priority();
        int v_k;
        lat = 1;
        do_reset(2);
        repeat (5) @(negedge clock);
        redirect_br = 1'b1;
        redirect_reg = 1'b1;
        br_target = 64'h100;
        reg_target = 64'h2000;
        @(negedge clock);
        redirect_br = 1'b0;
        redirect_reg = 1'b0;
        v_k = -1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (if_valid) begin
                v_k = i;
                break;
            end
            @(negedge clock);
        end
        n_checks++; if (v_k < 0) begin n_errors++; $display("FAIL priority_timeout got none required if_valid"); end
        n_checks++; if (if_pc !== 64'h2000) begin n_errors++; $display("FAIL priority_pc got %h required %h", if_pc, 64'h2000); end
        n_checks++; if (if_pc_link !== 64'h2004) begin n_errors++; $display("FAIL priority_link got %h required %h", if_pc_link, 64'h2004); end
    endtask

    task automatic test_wrap();
        logic [63:0] pcs[3];
        logic [63:0] links[3];
        int n;
        lat = 1;
        if_ready = 1'b1;
        do_reset(2);
        repeat (3) @(negedge clock);
        redirect_reg = 1'b1;
        reg_target = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clock);
        redirect_reg = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            #2;
            if (if_valid && if_ready) begin
                pcs[n] = if_pc;
                links[n] = if_pc_link;
                n++;
            end
            @(negedge clock);
        end
        n_checks++; if (n != 3) begin n_errors++; $display("FAIL wrap_count got %0d required 3", n); end
        n_checks++; if (pcs[1] !== 64'hFFFF_FFFF_FFFF_FFFC || links[1] !== 64'h0) begin
            n_errors++; $display("FAIL wrap_last got pc=%h link=%h required pc=fffffffffffffffc link=0", pcs[1], links[1]); end
        n_checks++; if (pcs[2] !== 64'h0 || links[2] !== 64'h4) begin
            n_errors++; $display("FAIL wrap_zero got pc=%h link=%h required pc=0 link=4", pcs[2], links[2]); end
        redirect_br = 1'b1;
        br_target = 64'h203;
        @(negedge clock);
        redirect_br = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (if_valid) begin
                n = 1;
                break;
            end
            @(negedge clock);
        end
        n_checks++; if (n != 1 || if_pc !== 64'h203 || if_pc_link !== 64'h207) begin
            n_errors++; $display("FAIL low_bits got pc=%h link=%h required pc=203 link=207", if_pc, if_pc_link); end
    endtask

    task automatic test_reset_mid();
        int h;
        int v_k;
        lat = 2;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        do_reset(2);
        h = -1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (imem_req_valid && imem_req_ready && imem_req_addr != RESET_PC) begin
                h = i;
                break;
            end
            @(negedge clock);
        end
        n_checks++; if (h < 0) begin n_errors++; $display("FAIL reset_mid_setup got none required handshake"); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #2;
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mid_empty got %b required 0", if_valid); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_errors++; $display("FAIL reset_mid_req got valid=%b addr=%h required valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC); end
        @(negedge clock);
        #2;
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mid_stale got %b required 0", if_valid); end
        v_k = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #2;
            if (if_valid) begin
                v_k = i;
                break;
            end
        end
        n_checks++; if (v_k < 0 || if_pc !== RESET_PC) begin n_errors++; $display("FAIL reset_mid_pc got %h required %h", if_pc, RESET_PC); end
    endtask

    task automatic test_random();
        lat = 0;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_br    = ($urandom_range(0, 29) == 0);
            redirect_reg   = ($urandom_range(0, 49) == 0);
            br_target      = {$urandom, $urandom};
            reg_target     = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                br_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            end
            @(negedge clock);
        end
        redirect_br = 1'b0;
        redirect_reg = 1'b0;
        imem_req_ready = 1'b0;
        if_ready = 1'b1;
        repeat (20) @(negedge clock);
        #2;
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL random_lost got %0d pending required 0", exp_q.size()); end
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL random_empty got %b required 0", if_valid); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_priority();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
